// File: rtl/par2ser_gearbox.sv
// Parallel-to-narrow-word gearbox: IN_W-bit words are buffered in a small FIFO
// and emitted MSB chunk first, one OUT_W chunk per clk_4f cycle, with fill at word gaps.
module par2ser_gearbox #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  IDLE_SYM = 8'hBC
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [IN_W-1:0]          data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [OUT_W-1:0]         data_out,
  output logic                     valid_out,
  output logic                     sow_out,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned REP   = (OUT_W + 7) / 8;

  // Fill symbol replicated from the LSB upward, then cut to the chunk width.
  localparam logic [8*REP-1:0] IDLE_REP = {REP{IDLE_SYM}};
  localparam logic [OUT_W-1:0] IDLE_W   = IDLE_REP[OUT_W-1:0];

  generate
    if (IN_W % OUT_W != 0) begin : g_bad_ratio
      $error("par2ser_gearbox: IN_W must be an integer multiple of OUT_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("par2ser_gearbox: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [IN_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [IN_W-1:0]  head;
  // Remaining chunks kept MSB-aligned; the low OUT_W bits are always zero,
  // which lets RATIO == 1 share the same shift path.
  logic [IN_W-1:0]  sreg;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  always_comb begin
    ready_out = !reset && (level < LW'(DEPTH));
    push      = valid_in && ready_out;
    pop       = (cnt == '0) && (level != '0);
    head      = mem[rd_ptr];
  end

  always_ff @(posedge clk_4f) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt       <= '0;
      sreg      <= '0;
      data_out  <= IDLE_W;
      valid_out <= 1'b0;
      sow_out   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (cnt != '0) begin
        data_out  <= sreg[IN_W-1 -: OUT_W];
        sreg      <= sreg << OUT_W;
        cnt       <= cnt - CNT_W'(1);
        valid_out <= 1'b1;
        sow_out   <= 1'b0;
      end else if (pop) begin
        data_out  <= head[IN_W-1 -: OUT_W];
        sreg      <= head << OUT_W;
        cnt       <= CNT_W'(RATIO - 1);
        valid_out <= 1'b1;
        sow_out   <= 1'b1;
      end else begin
        data_out  <= IDLE_W;
        valid_out <= 1'b0;
        sow_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_par2ser_gearbox.sv
// Randomised and directed bench for par2ser_gearbox: default build against a
// queue-based reference model, plus RATIO=1 and 16->4 builds with fixed vectors.
module tb_par2ser_gearbox;

  logic clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Default build: 32 -> 8, DEPTH 4, fill BC
  logic        rst_a = 1'b1, vld_a = 1'b0, rdy_a, vo_a, sow_a;
  logic [31:0] din_a = '0;
  logic [7:0]  dout_a;
  logic [2:0]  lvl_a;

  par2ser_gearbox #(.IN_W(32), .OUT_W(8), .DEPTH(4), .IDLE_SYM(8'hBC)) u_dut_a (
    .clk_4f(clk_4f), .reset(rst_a), .data_in(din_a), .valid_in(vld_a),
    .ready_out(rdy_a), .data_out(dout_a), .valid_out(vo_a), .sow_out(sow_a), .level(lvl_a));

  // RATIO == 1 build
  logic       rst_b = 1'b1, vld_b = 1'b0, rdy_b, vo_b, sow_b;
  logic [7:0] din_b = '0, dout_b;
  logic [2:0] lvl_b;

  par2ser_gearbox #(.IN_W(8), .OUT_W(8), .DEPTH(4), .IDLE_SYM(8'hBC)) u_dut_b (
    .clk_4f(clk_4f), .reset(rst_b), .data_in(din_b), .valid_in(vld_b),
    .ready_out(rdy_b), .data_out(dout_b), .valid_out(vo_b), .sow_out(sow_b), .level(lvl_b));

  // 16 -> 4 build with a 4-bit fill
  logic        rst_c = 1'b1, vld_c = 1'b0, rdy_c, vo_c, sow_c;
  logic [15:0] din_c = '0;
  logic [3:0]  dout_c;
  logic [2:0]  lvl_c;

  par2ser_gearbox #(.IN_W(16), .OUT_W(4), .DEPTH(4), .IDLE_SYM(8'h0C)) u_dut_c (
    .clk_4f(clk_4f), .reset(rst_c), .data_in(din_c), .valid_in(vld_c),
    .ready_out(rdy_c), .data_out(dout_c), .valid_out(vo_c), .sow_out(sow_c), .level(lvl_c));

  // Reference model for the default build: queued words plus pending chunks.
  logic [31:0] mq[$];
  logic [7:0]  pend[$];
  logic [7:0]  e_dout;
  logic        e_vo, e_sow;

  // Called at a falling edge: drive, check ready, advance model, check after edge.
  task automatic step_a(input logic rst, input logic vld, input logic [31:0] d);
    logic        e_rdy;
    logic [31:0] w;
    rst_a = rst; vld_a = vld; din_a = d;
    #1;
    e_rdy = !rst && (mq.size() < 4);
    check_eq("a_ready", {63'd0, rdy_a}, {63'd0, e_rdy});
    if (rst) begin
      mq.delete(); pend.delete();
      e_dout = 8'hBC; e_vo = 1'b0; e_sow = 1'b0;
    end else begin
      if (pend.size() > 0) begin
        e_dout = pend.pop_front(); e_vo = 1'b1; e_sow = 1'b0;
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        e_dout = w[31:24]; e_vo = 1'b1; e_sow = 1'b1;
        for (int k = 2; k >= 0; k--) pend.push_back(w[8*k +: 8]);
      end else begin
        e_dout = 8'hBC; e_vo = 1'b0; e_sow = 1'b0;
      end
      if (vld && e_rdy) mq.push_back(d);
    end
    @(negedge clk_4f);
    check_eq("a_data",  {56'd0, dout_a}, {56'd0, e_dout});
    check_eq("a_valid", {63'd0, vo_a},   {63'd0, e_vo});
    check_eq("a_sow",   {63'd0, sow_a},  {63'd0, e_sow});
    check_eq("a_level", {61'd0, lvl_a},  64'(mq.size()));
  endtask

  task automatic step_b(input logic vld, input logic [7:0] d, input logic [7:0] xd,
                        input logic xv, input logic xs, input logic [2:0] xl);
    rst_b = 1'b0; vld_b = vld; din_b = d;
    #1;
    check_eq("b_ready", {63'd0, rdy_b}, 64'd1);
    @(negedge clk_4f);
    check_eq("b_data",  {56'd0, dout_b}, {56'd0, xd});
    check_eq("b_valid", {63'd0, vo_b},   {63'd0, xv});
    check_eq("b_sow",   {63'd0, sow_b},  {63'd0, xs});
    check_eq("b_level", {61'd0, lvl_b},  {61'd0, xl});
  endtask

  task automatic step_c(input logic vld, input logic [15:0] d, input logic [3:0] xd,
                        input logic xv, input logic xs, input logic [2:0] xl);
    rst_c = 1'b0; vld_c = vld; din_c = d;
    @(negedge clk_4f);
    check_eq("c_data",  {60'd0, dout_c}, {60'd0, xd});
    check_eq("c_valid", {63'd0, vo_c},   {63'd0, xv});
    check_eq("c_sow",   {63'd0, sow_c},  {63'd0, xs});
    check_eq("c_level", {61'd0, lvl_c},  {61'd0, xl});
  endtask

  initial begin
    int unsigned pct;
    @(negedge clk_4f);

    // Reset with pushes offered, then release and idle
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b1, $urandom);
    check_eq("rst_fill_c", {60'd0, dout_c}, 64'hC);
    check_eq("rst_ready_b", {63'd0, rdy_b}, 64'd0);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, '0);

    // Single word
    step_a(1'b0, 1'b1, 32'hA1B2C3D4);
    for (int i = 0; i < 6; i++) step_a(1'b0, 1'b0, '0);

    // Back-to-back words
    step_a(1'b0, 1'b1, 32'h11223344);
    step_a(1'b0, 1'b1, 32'h55667788);
    for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, '0);

    // Backpressure: six consecutive offers into a four-deep FIFO
    for (int i = 0; i < 6; i++) step_a(1'b0, 1'b1, 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 24; i++) step_a(1'b0, 1'b0, '0);

    // Reset right after B2 is presented
    step_a(1'b0, 1'b1, 32'hA1B2C3D4);
    step_a(1'b0, 1'b0, '0);
    step_a(1'b0, 1'b0, '0);
    check_eq("mid_b2", {56'd0, dout_a}, 64'hB2);
    step_a(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step_a(1'b0, 1'b0, '0);

    // Random traffic with occasional resets
    for (int blk = 0; blk < 15; blk++) begin
      pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++)
        step_a($urandom_range(0, 299) == 0, $urandom_range(1, 100) <= pct, $urandom);
    end

    // RATIO == 1: byte appears two edges after the push
    step_b(1'b1, 8'h5A, 8'hBC, 1'b0, 1'b0, 3'd1);
    step_b(1'b0, 8'h00, 8'h5A, 1'b1, 1'b1, 3'd0);
    step_b(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 3'd0);
    step_b(1'b1, 8'h01, 8'hBC, 1'b0, 1'b0, 3'd1);
    step_b(1'b1, 8'h02, 8'h01, 1'b1, 1'b1, 3'd1);
    step_b(1'b1, 8'h03, 8'h02, 1'b1, 1'b1, 3'd1);
    step_b(1'b0, 8'h00, 8'h03, 1'b1, 1'b1, 3'd0);
    step_b(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 3'd0);

    // 16 -> 4 with fill C
    step_c(1'b1, 16'hBEEF, 4'hC, 1'b0, 1'b0, 3'd1);
    step_c(1'b0, 16'h0000, 4'hB, 1'b1, 1'b1, 3'd0);
    step_c(1'b0, 16'h0000, 4'hE, 1'b1, 1'b0, 3'd0);
    step_c(1'b0, 16'h0000, 4'hE, 1'b1, 1'b0, 3'd0);
    step_c(1'b0, 16'h0000, 4'hF, 1'b1, 1'b0, 3'd0);
    step_c(1'b0, 16'h0000, 4'hC, 1'b0, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
